// File: rtl/vram_dma_pkg.sv
// Shared types and VRAM map constants for the CPU-to-VRAM bulk copy engine.
// Optional fill mode is enabled by defining VRAM_DMA_FILL_EN.
package vram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [11:0] VRAM_PMF_BASE = 12'h000;
    localparam logic [11:0] VRAM_OBM_BASE = 12'h800;
    localparam int          VRAM_OBM_SIZE = 256;
    localparam int          MAX_LEN       = 256;

endpackage

// File: rtl/vram_dma.sv
// Copies up to 256 bytes from CPU space into VRAM, writing only inside the video write window.
// 2 enabled cycles per byte in copy mode; with VRAM_DMA_FILL_EN defined, fill mode writes 1 byte per writable cycle.
module vram_dma
    import vram_dma_pkg::*;
#(
    parameter int VRAM_ADDR_WIDTH = 12,
    parameter int SRC_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 9
) (
    input  logic                       cpu_clk,
    input  logic                       rst,
    input  logic                       cpu_clk_enable,
    input  logic                       writable,
    input  logic                       start,
    input  logic [SRC_ADDR_WIDTH-1:0]  src_base,
    input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
    input  logic [LEN_WIDTH-1:0]       length,
`ifdef VRAM_DMA_FILL_EN
    input  logic                       fill_mode,
    input  logic [7:0]                 fill_value,
`endif
    output logic [SRC_ADDR_WIDTH-1:0]  mem_addr,
    output logic                       mem_rd,
    input  logic [7:0]                 mem_rdata,
    input  logic                       mem_valid,
    output logic [7:0]                 vram_data,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic                       vram_write_enable,
    output logic                       busy,
    output logic                       done
);

    state_t                     r_state;
    state_t                     w_next;
    logic [SRC_ADDR_WIDTH-1:0]  r_src_ptr;
    logic [VRAM_ADDR_WIDTH-1:0] r_dst_ptr;
    logic [LEN_WIDTH-1:0]       r_remaining;
    logic [7:0]                 r_vram_data;
    logic [LEN_WIDTH-1:0]       w_len_clamped;
    logic                       w_start_fill;
    logic                       w_fill;
    logic                       w_commit;

`ifdef VRAM_DMA_FILL_EN
    logic r_fill_mode;
    assign w_start_fill = fill_mode;
    assign w_fill       = r_fill_mode;
`else
    assign w_start_fill = 1'b0;
    assign w_fill       = 1'b0;
`endif

    assign w_len_clamped = (length > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : length;
    // A byte is only consumed when the strobe was actually visible to the renderers.
    assign w_commit      = (r_state == WRITE) && writable;

    assign mem_addr          = r_src_ptr;
    assign mem_rd            = (r_state == READ);
    assign vram_data         = r_vram_data;
    assign vram_address      = r_dst_ptr;
    assign vram_write_enable = (r_state == WRITE) && writable;
    assign busy              = (r_state == READ) || (r_state == WRITE);
    assign done              = (r_state == FIN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length == '0)      w_next = FIN;
                    else if (w_start_fill) w_next = WRITE;
                    else                   w_next = READ;
                end
            end
            READ: begin
                if (mem_valid) w_next = WRITE;
            end
            WRITE: begin
                if (writable) begin
                    if (r_remaining == LEN_WIDTH'(1)) w_next = FIN;
                    else if (w_fill)                  w_next = WRITE;
                    else                              w_next = READ;
                end
            end
            FIN: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_vram_data <= '0;
`ifdef VRAM_DMA_FILL_EN
            r_fill_mode <= 1'b0;
`endif
        end else if (cpu_clk_enable) begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_src_ptr   <= src_base;
                r_dst_ptr   <= dst_base;
                r_remaining <= w_len_clamped;
`ifdef VRAM_DMA_FILL_EN
                r_fill_mode <= fill_mode;
                if (fill_mode) r_vram_data <= fill_value;
`endif
            end
            if (r_state == READ && mem_valid) begin
                r_vram_data <= mem_rdata;
            end
            if (w_commit) begin
                r_src_ptr   <= r_src_ptr + 1'b1;
                r_dst_ptr   <= r_dst_ptr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: copy, write-window gaps, zero length, wrap, clamp, reset abort, ignored starts.
module tb_vram_dma;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_clk_enable = 1'b1;
    logic        writable = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_base = '0;
    logic [11:0] dst_base = '0;
    logic [8:0]  length = '0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic [7:0]  vram_data;
    logic [11:0] vram_address;
    logic        vram_write_enable;
    logic        busy;
    logic        done;
`ifdef VRAM_DMA_FILL_EN
    logic        fill_mode = 1'b0;
    logic [7:0]  fill_value = '0;
`endif

    int n_assert = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cnt;
    logic we_seen;
    logic [11:0] wq_a[$];
    logic [7:0]  wq_d[$];
    logic [15:0] rq[$];

    vram_dma dut (
        .cpu_clk(cpu_clk), .rst(rst), .cpu_clk_enable(cpu_clk_enable),
        .writable(writable), .start(start), .src_base(src_base),
        .dst_base(dst_base), .length(length),
`ifdef VRAM_DMA_FILL_EN
        .fill_mode(fill_mode), .fill_value(fill_value),
`endif
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .vram_data(vram_data),
        .vram_address(vram_address), .vram_write_enable(vram_write_enable),
        .busy(busy), .done(done)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        case (a)
            16'h0200: src_byte = 8'h11;
            16'h0201: src_byte = 8'h22;
            16'h0202: src_byte = 8'h33;
            16'h0203: src_byte = 8'h44;
            default:  src_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // Source memory answers in the same cycle.
    always_comb begin
        mem_rdata = src_byte(mem_addr);
        mem_valid = mem_rd;
    end

    // Renderers sample the write port on negedge.
    always @(negedge cpu_clk) begin
        if (cpu_clk_enable && vram_write_enable) begin
            wq_a.push_back(vram_address);
            wq_d.push_back(vram_data);
        end
        if (cpu_clk_enable && mem_rd && mem_valid) rq.push_back(mem_addr);
        if (cpu_clk_enable && done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wq_a.delete(); wq_d.delete(); rq.delete(); done_cnt = 0;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [11:0] d, input logic [8:0] l);
        src_base = s; dst_base = d; length = l; start = 1'b1;
        @(posedge cpu_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        cnt = 0;
        while (!done && cnt < budget) begin
            @(posedge cpu_clk); #1;
            cnt++;
        end
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (wq_a.size() < n && k < budget) begin
            @(posedge cpu_clk); #1;
            k++;
        end
        chk(tag, wq_a.size(), n);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_we", vram_write_enable, 0);
        chk("rst_addr", {mem_addr, 4'h0, vram_address, vram_data}, 0);
        @(posedge cpu_clk); #1;
        rst = 1'b1;
        @(posedge cpu_clk); #1;

        // Basic 4-byte copy into OBM
        clear_log();
        do_start(16'h0200, 12'h800, 9'd4);
        chk("t1_busy", busy, 1);
        wait_done(50);
        chk("t1_latency", cnt, 8);
        chk("t1_nwr", wq_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_a%0d", i), wq_a[i], 12'h800 + i);
            chk($sformatf("t1_d%0d", i), wq_d[i], src_byte(16'h0200 + i));
        end
        chk("t1_nrd", rq.size(), 4);
        @(posedge cpu_clk); #1;
        chk("t1_done_once", done_cnt, 1);
        chk("t1_busy_after", {busy, done}, 0);

        // Write window closes for 20 cycles after the 2nd byte
        clear_log();
        do_start(16'h0200, 12'h800, 9'd4);
        wait_writes("t2_two", 2, 20);
        writable = 1'b0;
        we_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge cpu_clk); #1;
            we_seen |= vram_write_enable;
            if (i == 3) chk("t2_mid_addr", vram_address, 12'h802);
        end
        chk("t2_no_strobe", we_seen, 0);
        chk("t2_gap_nwr", wq_a.size(), 2);
        chk("t2_hold_addr", vram_address, 12'h802);
        chk("t2_hold_data", vram_data, 8'h33);
        chk("t2_busy", busy, 1);
        writable = 1'b1;
        wait_done(50);
        chk("t2_nwr", wq_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_a%0d", i), wq_a[i], 12'h800 + i);
            chk($sformatf("t2_d%0d", i), wq_d[i], src_byte(16'h0200 + i));
        end
        @(posedge cpu_clk); #1;

        // Zero length
        clear_log();
        do_start(16'h0200, 12'h100, 9'd0);
        chk("t3_done_now", done, 1);
        @(posedge cpu_clk); #1;
        chk("t3_done_drop", done, 0);
        chk("t3_nrd", rq.size(), 0);
        chk("t3_nwr", wq_a.size(), 0);
        chk("t3_done_once", done_cnt, 1);

        // Destination wrap
        clear_log();
        do_start(16'h0200, 12'hFFE, 9'd3);
        wait_done(50);
        chk("t4_nwr", wq_a.size(), 3);
        chk("t4_a0", wq_a[0], 12'hFFE);
        chk("t4_a1", wq_a[1], 12'hFFF);
        chk("t4_a2", wq_a[2], 12'h000);
        chk("t4_d2", wq_d[2], 8'h33);
        @(posedge cpu_clk); #1;

        // Source wrap
        clear_log();
        do_start(16'hFFFF, 12'h040, 9'd2);
        wait_done(50);
        chk("t5_nrd", rq.size(), 2);
        chk("t5_r0", rq[0], 16'hFFFF);
        chk("t5_r1", rq[1], 16'h0000);
        chk("t5_d1", wq_d[1], src_byte(16'h0000));
        @(posedge cpu_clk); #1;

        // Starts while busy are ignored
        clear_log();
        do_start(16'h0200, 12'h300, 9'd3);
        for (int i = 0; i < 3; i++) do_start(16'h1234, 12'h500, 9'd5);
        wait_done(50);
        chk("t6_nwr", wq_a.size(), 3);
        chk("t6_a0", wq_a[0], 12'h300);
        chk("t6_a2", wq_a[2], 12'h302);
        chk("t6_d2", wq_d[2], 8'h33);
        // start coinciding with done is dropped
        start = 1'b1; src_base = 16'h0200; dst_base = 12'h600; length = 9'd1;
        @(posedge cpu_clk); #1;
        start = 1'b0;
        @(posedge cpu_clk); #1;
        chk("t6_fin_start_busy", busy, 0);
        chk("t6_fin_start_nrd", rq.size(), 3);

        // Disabled clock enable freezes the engine
        cpu_clk_enable = 1'b0;
        do_start(16'h0200, 12'h700, 9'd1);
        @(posedge cpu_clk); #1;
        chk("t7_en_hold", {busy, mem_rd, done}, 0);
        cpu_clk_enable = 1'b1;
        @(posedge cpu_clk); #1;

        // Reset mid-transfer, then recovery
        clear_log();
        do_start(16'h0200, 12'h200, 9'd8);
        wait_writes("t8_two", 2, 20);
        rst = 1'b0;
        #1;
        chk("t8_abort_ctl", {busy, done, mem_rd, vram_write_enable}, 0);
        chk("t8_abort_addr", {mem_addr, 4'h0, vram_address, vram_data}, 0);
        @(posedge cpu_clk); #1;
        rst = 1'b1;
        chk("t8_nwr_abort", wq_a.size(), 2);
        @(posedge cpu_clk); #1;
        clear_log();
        do_start(16'h0201, 12'h010, 9'd1);
        wait_done(20);
        chk("t8_lat", cnt, 2);
        chk("t8_nwr", wq_a.size(), 1);
        chk("t8_a0", wq_a[0], 12'h010);
        chk("t8_d0", wq_d[0], 8'h22);
        @(posedge cpu_clk); #1;

        // Over-length request is clamped to 256 bytes
        clear_log();
        do_start(16'h0000, 12'h800, 9'h1FF);
        wait_done(600);
        chk("t9_lat", cnt, 512);
        chk("t9_nwr", wq_a.size(), 256);
        chk("t9_last_a", wq_a[255], 12'h8FF);
        chk("t9_last_d", wq_d[255], src_byte(16'h00FF));
        @(posedge cpu_clk); #1;

`ifdef VRAM_DMA_FILL_EN
        // OBM clear by fill
        clear_log();
        fill_mode = 1'b1; fill_value = 8'hFF;
        do_start(16'h0000, 12'h800, 9'd256);
        fill_mode = 1'b0;
        wait_done(400);
        chk("tf_lat", cnt, 256);
        chk("tf_nwr", wq_a.size(), 256);
        chk("tf_nrd", rq.size(), 0);
        chk("tf_a0", wq_a[0], 12'h800);
        chk("tf_a255", wq_a[255], 12'h8FF);
        chk("tf_d128", wq_d[128], 8'hFF);
        @(posedge cpu_clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
